// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // The idle counter only ever holds 0 .. cycles-1.
  function automatic int timeout_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter; pulses expired on the cycle before the timeout edge.
module loader_timeout
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A byte arriving on the final idle cycle still wins over the timeout.
  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a framed, XOR-checksummed byte stream and
// holds the processor in reset until a complete image has been accepted.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          loaded,
  output logic          error,
  output logic [15:0]   words_written
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  loader_state_t         state_q;
  logic [15:0]           n_q;
  logic [15:0]           ww_q;
  logic [1:0]            lane_q;
  logic [23:0]           word_q;
  logic [7:0]            xor_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  cpu_reset_q;
  logic                  loaded_q;
  logic                  error_q;

  logic [15:0] ww_d;
  logic [7:0]  xor_d;
  logic [15:0] n_d;
  logic        tmo_enable;
  logic        tmo_expired;

  assign ww_d       = ww_q + 16'd1;
  assign xor_d      = xor_q ^ bus.rx_data;
  assign n_d        = {bus.rx_data, n_q[7:0]};
  assign tmo_enable = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == DATA)   || (state_q == CHECK);

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.rx_valid),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      n_q         <= '0;
      ww_q        <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (bus.rx_valid) begin
        unique case (state_q)
          SYNC, ERROR: begin
            if (bus.rx_data == LOADER_MAGIC) begin
              state_q <= CNT_LO;
              error_q <= 1'b0;
              ww_q    <= '0;
              xor_q   <= '0;
              lane_q  <= '0;
            end
          end
          CNT_LO: begin
            n_q[7:0] <= bus.rx_data;
            xor_q    <= xor_d;
            state_q  <= CNT_HI;
          end
          CNT_HI: begin
            n_q   <= n_d;
            xor_q <= xor_d;
            if ({1'b0, n_d} > CAPACITY) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else if (n_d == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            xor_q  <= xor_d;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_WIDTH'(ww_q);
              mem_wdata_q <= {bus.rx_data, word_q};
              ww_q        <= ww_d;
              if (ww_d == n_q) state_q <= CHECK;
            end else begin
              word_q[{lane_q, 3'b000} +: 8] <= bus.rx_data;
            end
          end
          CHECK: begin
            if (bus.rx_data == xor_q) begin
              state_q     <= DONE;
              loaded_q    <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
          DONE: begin
          end
          default: state_q <= SYNC;
        endcase
      end else if (tmo_expired) begin
        state_q <= ERROR;
        error_q <= 1'b1;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign loaded        = loaded_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed frame table, timing sequences and random frames
// checked against a frame-parsing reference model.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_reset;
  logic        loaded;
  logic        error;
  logic [15:0] words_written;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .cpu_reset     (cpu_reset),
    .loaded        (loaded),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr.push_back(32'(bus.mem_addr));
      got_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] got_word(input int k);
    return (k < got_data.size()) ? got_data[k] : 32'h0;
  endfunction

  // Reference model: parses the whole byte sequence as frames from reset.
  logic [31:0] m_data[$];
  int unsigned m_addr[$];
  bit          m_loaded;
  bit          m_err;
  int          m_ww;

  task automatic model_run(input logic [7:0] q[$]);
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    i = 0;
    m_data.delete();
    m_addr.delete();
    m_loaded = 0;
    m_err    = 0;
    m_ww     = 0;
    while (i < q.size() && !m_loaded) begin
      if (q[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      m_err = 0;
      m_ww  = 0;
      if (i + 2 > q.size()) return;
      n = int'(q[i]) | (int'(q[i+1]) << 8);
      x = q[i] ^ q[i+1];
      i += 2;
      if (n > (1 << AW)) begin
        m_err = 1;
        continue;
      end
      for (int k = 0; k < n; k++) begin
        if (i + 4 > q.size()) return;
        w = {q[i+3], q[i+2], q[i+1], q[i]};
        x = x ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
        i += 4;
        m_addr.push_back(k);
        m_data.push_back(w);
        m_ww++;
      end
      if (i >= q.size()) return;
      if (q[i] == x) m_loaded = 1;
      else m_err = 1;
      i++;
    end
  endtask

  typedef struct {
    int           len;
    logic [255:0] bytes;
    bit           loaded;
    bit           err;
    int           ww;
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  stim[$];

  initial begin
    logic [7:0] b;
    logic [7:0] x;
    int         n;
    int         mode;
    bit         early;

    vecs[0] = '{12, 256'hA5_02_00_13_05_10_00_93_05_20_00_B2, 1'b1, 1'b0, 2, 2,
                32'h00100513, 32'h00200593};
    vecs[1] = '{12, 256'hA5_02_00_13_05_10_00_93_05_20_00_B3, 1'b0, 1'b1, 2, 2,
                32'h00100513, 32'h00200593};
    vecs[2] = '{24, 256'hA5_02_00_13_05_10_00_93_05_20_00_B3_A5_02_00_13_05_10_00_93_05_20_00_B2,
                1'b1, 1'b0, 2, 4, 32'h00100513, 32'h00200593};
    vecs[3] = '{3, 256'hA5_01_04, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0};
    vecs[4] = '{9, 256'hFF_00_A5_00_00_00_A5_01_00, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state, observed before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].len; i++)
        send_byte(vecs[v].bytes[(vecs[v].len - 1 - i) * 8 +: 8]);
      idle(3);
      check($sformatf("vec%0d_loaded", v), 32'(loaded), 32'(vecs[v].loaded));
      check($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].err));
      check($sformatf("vec%0d_cpu_reset", v), 32'(cpu_reset), 32'(!vecs[v].loaded));
      check($sformatf("vec%0d_words", v), 32'(words_written), 32'(vecs[v].ww));
      check($sformatf("vec%0d_nwrites", v), 32'(got_data.size()), 32'(vecs[v].nwr));
      check($sformatf("vec%0d_w0", v), got_word(0), vecs[v].w0);
      check($sformatf("vec%0d_w1", v), got_word(1), vecs[v].w1);
    end

    // Write latency and cpu_reset release timing.
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
    send_byte(8'h00);
    check("lat_we0", 32'(bus.mem_we), 32'd1);
    check("lat_addr0", 32'(bus.mem_addr), 32'd0);
    check("lat_data0", bus.mem_wdata, 32'h00100513);
    check("lat_words0", 32'(words_written), 32'd1);
    idle(1);
    check("lat_we_drop", 32'(bus.mem_we), 32'd0);
    check("lat_addr_hold", 32'(bus.mem_addr), 32'd0);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20);
    send_byte(8'h00);
    check("lat_addr1", 32'(bus.mem_addr), 32'd1);
    check("lat_data1", bus.mem_wdata, 32'h00200593);
    check("lat_words1", 32'(words_written), 32'd2);
    check("lat_cpu_reset_before", 32'(cpu_reset), 32'd1);
    send_byte(8'hB2);
    check("lat_cpu_reset_after", 32'(cpu_reset), 32'd0);
    check("lat_loaded_after", 32'(loaded), 32'd1);

    // Oversize count flags immediately after the high count byte.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01);
    check("over_before", 32'(error), 32'd0);
    send_byte(8'h04);
    check("over_after", 32'(error), 32'd1);

    // Timeout exactly TMO edges after the last byte.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    early = 0;
    for (int j = 1; j < TMO; j++) begin
      @(posedge clk);
      #1;
      if (error) early = 1;
    end
    check("tmo_not_early", 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
    check("tmo_nwrites", 32'(got_data.size()), 32'd0);

    // Asynchronous reset mid-frame, then a fresh load.
    do_reset();
    for (int i = 0; i < 12; i++)
      send_byte(vecs[1].bytes[(11 - i) * 8 +: 8]);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    check("mid_pre_addr", 32'(bus.mem_addr), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("mid_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_mem_wdata", bus.mem_wdata, 32'd0);
    check("mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_error", 32'(error), 32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_loaded", 32'(loaded), 32'd0);
    check("mid_words", 32'(words_written), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < 12; i++)
      send_byte(vecs[0].bytes[(11 - i) * 8 +: 8]);
    idle(2);
    check("mid_reload_loaded", 32'(loaded), 32'd1);
    check("mid_reload_w0", got_word(0), 32'h00100513);
    check("mid_reload_w1", got_word(1), 32'h00200593);

    // Random frame sequences against the reference model.
    for (int it = 0; it < 40; it++) begin
      stim.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        stim.push_back(b);
      end
      repeat ($urandom_range(1, 3)) begin
        mode = $urandom_range(0, 9);
        stim.push_back(8'hA5);
        if (mode == 0) begin
          n = (1 << AW) + 1 + $urandom_range(0, 100);
          stim.push_back(n[7:0]);
          stim.push_back(n[15:8]);
        end else begin
          n = $urandom_range(0, 5);
          stim.push_back(n[7:0]);
          stim.push_back(n[15:8]);
          x = n[7:0] ^ n[15:8];
          for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            stim.push_back(b);
          end
          if (mode == 1) x = x ^ 8'($urandom_range(1, 255));
          stim.push_back(x);
        end
      end
      model_run(stim);
      do_reset();
      foreach (stim[i]) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_byte(stim[i]);
      end
      idle(3);
      check("rnd_loaded", 32'(loaded), 32'(m_loaded));
      check("rnd_error", 32'(error), 32'(m_err));
      check("rnd_cpu_reset", 32'(cpu_reset), 32'(!m_loaded));
      check("rnd_words", 32'(words_written), 32'(m_ww));
      check("rnd_nwrites", 32'(got_data.size()), 32'(m_data.size()));
      foreach (m_data[k]) begin
        if (k < got_data.size()) begin
          check("rnd_waddr", got_addr[k], m_addr[k]);
          check("rnd_wdata", got_data[k], m_data[k]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream (UART receiver output), replacing simulation-only `$readmemh` preloading on hardware. It sits between the UART RX block and the instruction-memory write port in `top`. It holds the processor in reset until a complete, checksum-verified image has been written.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `TIMEOUT_CYCLES`, 100000: idle clocks allowed between bytes once a frame has started.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `mem_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  processor reset; high until the load succeeds.
- `loaded`  out  1  sticky; the image was accepted.
- `error`  out  1  the frame failed (checksum, oversize or timeout).
- `words_written`  out  16  count of words written in the current or last frame.

## Operation

Frame format:
- Magic byte `0xA5`.
- Word count N as 2 bytes, little-endian.
- 4·N data bytes, little-endian per word; word i is written to address i.
- One checksum byte: the XOR of every byte after the magic byte, up to but not including the checksum.

States:
- **SYNC**: discard bytes until `0xA5` arrives, then go to CNT_LO.
- **CNT_LO**, **CNT_HI**: latch N.
  - After CNT_HI: if N > 2^ADDR_WIDTH, go to ERROR.
  - If N == 0, go to CHECK.
  - Otherwise go to DATA.
- **DATA**: assemble bytes into a word, least-significant byte first.
  - On the 4th byte, write the word and increment `words_written`.
  - After word N-1 is written, go to CHECK.
- **CHECK**: compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERROR.
- **DONE**: `loaded`=1 and `cpu_reset`=0. All further `rx_valid` bytes are ignored until `reset`.
- **ERROR**: `error`=1 and `cpu_reset` stays 1.
  - A byte `0xA5` restarts the load: go to CNT_LO, clear `error`, `words_written` and the running XOR.
  - Any other byte is ignored.

Rules:
- Memory words already written are not rolled back on an error.
- Timeout applies in CNT_LO, CNT_HI, DATA and CHECK.
  - The idle counter clears on every `rx_valid`.
  - When the counter reaches `TIMEOUT_CYCLES`, go to ERROR.
  - No timeout applies in SYNC, DONE or ERROR.
- The running XOR and byte lane index clear when `0xA5` is accepted in SYNC or ERROR.
- Reset at any time, including mid-frame, returns to SYNC with all outputs at reset values. Memory contents are not cleared.

## Timing

Reset values of outputs:
- `cpu_reset`=1.
- `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `loaded`=0, `error`=0, `words_written`=0.

Cycle-level behaviour:
- All outputs are registered.
- A byte is consumed at the rising edge where `rx_valid`=1. `rx_valid` never asserts on consecutive cycles faster than one byte per clock, and the block accepts back-to-back bytes.
- Write latency is 1 cycle. When the 4th byte of a word is sampled at edge k, `mem_we`=1 with the final `mem_addr`/`mem_wdata` during the cycle after edge k, and `mem_we` returns to 0 at edge k+1.
- `words_written` updates on the same edge that `mem_we` rises.
- When the checksum byte is sampled at edge k, `cpu_reset` falls and `loaded` rises (or `error` rises on mismatch) after edge k.
- A timeout is flagged (`error` rises) exactly `TIMEOUT_CYCLES` edges after the last accepted byte.
- `mem_addr` holds its last value between writes.

## Structure

- `loader_pkg` contains:
  - the `loader_state_t` enum (SYNC, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR);
  - `LOADER_MAGIC` = 8'hA5;
  - the `$clog2`-derived timeout counter width.
- One sub-module, `loader_timeout`: the idle counter with inputs `clear` and `enable` and a one-cycle output pulse `expired`.
- Word assembly, checksum and the FSM live in `imem_loader`.
- `top` connects `cpu_reset` ORed with `reset` to the processor, and muxes the instruction-memory write port.

## Test plan

- **Good frame.** Send `A5 02 00 13 05 10 00 93 05 20 00 B2`. Expect:
  - writes `mem[0]`=0x00100513 and `mem[1]`=0x00200593;
  - `words_written`=2 and `loaded`=1;
  - `cpu_reset` falls 1 cycle after `B2`.
- **Bad checksum, then recovery.** Send the same frame with a final byte of `B3`. Expect both words written, `error`=1 and `cpu_reset`=1. Then resend the good frame: expect `error`=0 and `loaded`=1.
- **Oversize count.** With ADDR_WIDTH=10, send `A5 01 04` (N=1025). Expect ERROR immediately after the count bytes and no `mem_we` pulse.
- **Resync, empty image, ignore after DONE.** Send `FF 00 A5 00 00 00`. Expect:
  - the leading junk is ignored;
  - N=0 with checksum 0x00 gives `loaded`=1 and zero writes;
  - a following `A5 01 00` is ignored.
- **Timeout.** With TIMEOUT_CYCLES=50, send `A5 01 00 13` then stop. Expect `error`=1 exactly 50 cycles after `13`, and no write.
- **Reset mid-frame.** Assert `reset` asynchronously between the 2nd and 3rd data bytes. Expect all outputs at reset values immediately (not waiting for a clock edge) and the state at SYNC. A fresh good frame then loads correctly.
